hub75_scan_reader: RTL
======================

Name: hub75_scan_reader

Overview:
- Read side of the double-buffered display memory.
- Walks the front bank row by row and column by column, and serialises each pixel as 1-bit colour planes onto a HUB75-style LED panel (r/g/b, sclk, lat, oe_n, row address), using binary-weighted on-times for brightness.
- Owns the memory's `flip` signal. Swaps banks only at a frame boundary, on request from the writer via a req/ack handshake.

Parameters:
- rows, 8, panel scan rows; memory row count.
- columns, 32, pixels per row; memory column count.
- width, 24, pixel word width: R=[23:16], G=[15:8], B=[7:0].
- planes, 8, bit planes shown per channel (1..8); plane p uses channel bit (8-planes)+p.
- base_time, 1, oe_n low cycles for plane 0; plane p shows base_time<<p cycles.
- blank_cycles, 2, oe_n-high dead cycles before each latch (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- swap_req  in  1  writer requests bank swap; level, held until swap_ack
- swap_ack  out  1  one-cycle pulse in the cycle flip toggles
- flip  out  1  bank select to memory; front bank = flip
- rrow  out  clog2(rows)  memory read row
- rcol  out  clog2(columns)  memory read column
- rdata  in  width  memory read data, valid one clk after rrow/rcol
- frame_start  out  1  one-cycle pulse at first SHIFT cycle of row 0 plane 0
- r, g, b  out  1 each  panel serial colour data
- sclk  out  1  panel shift clock
- lat  out  1  panel latch
- oe_n  out  1  panel output enable, active low
- addr  out  clog2(rows)  panel row address

Behaviour:
- Reset (async, rst_n=0): all outputs 0 except oe_n=1; flip=0; state=SHIFT, row=0, plane=0, col=0.
  - Reset mid-operation aborts immediately. The first SHIFT after release is row 0, plane 0, and pulses frame_start.
- All panel outputs are registered. rrow always equals the current row counter.
- States cycle SHIFT -> BLANK -> LATCH -> SHOW -> SHIFT.
- SHIFT: exactly 2*columns+2 cycles. oe_n=1, lat=0.
  - Column c address goes out on rcol; rdata is captured one clk later.
  - r/g/b are set to bit (8-planes)+plane of the R/G/B fields while sclk=0. sclk=1 on the following cycle.
  - This gives exactly `columns` sclk high pulses of 1 clk each, period 2 clk, columns in order 0..columns-1.
  - r/g/b are stable for the whole high pulse and the preceding low cycle. sclk=0 at SHIFT exit.
- BLANK: blank_cycles cycles. oe_n=1, sclk=0, r/g/b hold.
- LATCH: 1 cycle. lat=1; addr<=row in this cycle; oe_n=1.
- SHOW: base_time<<plane cycles. oe_n=0, lat=0; addr is stable throughout.
- Advance at SHOW end:
  - plane++.
  - If plane==planes-1: plane<=0, row++.
  - If row==rows-1 as well: row<=0, frame end.
- Frame end with swap_req=1: flip toggles and swap_ack pulses in that same cycle; the new frame reads the new front bank.
  - If swap_req=0, flip is unchanged.
  - flip never changes mid-frame, even if swap_req rises mid-frame.
  - swap_req held across several frames is acked only once, at the first frame end seen.
  - The writer must drop swap_req after ack. Still high at the next frame end means another swap.
- Frame length with defaults: 8 rows x (8x(66+2+1) + 255) = 6456 clk.
- addr changes only while oe_n=1. Counters wrap modulo rows/columns/planes; no out-of-range addresses.

Test Plan:
- Reset: hold rst_n=0 and pulse clk -> oe_n=1, all other outputs 0, flip=0. Release -> frame_start pulses on the first clk.
- Shift data: bank 0 row 0 = 0xFF0000 at col 0, 0x00FF00 at col 1, 0x0000FF at col 2, 0 elsewhere; planes=8 -> every plane-0 sclk rise sees (r,g,b) = 100, 010, 001, then 000. Exactly 32 sclk pulses per SHIFT.
- Plane weighting: base_time=1 -> oe_n low runs of 1,2,4,...,128 clk for row 0, then addr=1 for the next row. lat is high exactly once per plane, always while oe_n=1.
- Frame timing: frame_start-to-frame_start interval = 6456 clk. rrow/addr sequence is 0..7, then wraps to 0.
- Swap handshake: assert swap_req at clk 100 -> flip stays 0 until the frame end (clk 6456), then toggles with a 1-clk swap_ack. Frame 2 data comes from bank 1.
- Mid-shift reset: rst_n low during row 3 SHIFT -> outputs return to reset values asynchronously; on release, scanning restarts at row 0, plane 0.

Source files
------------

// File: rtl/hub75_scan_reader.sv
// hub75_scan_reader
// Read side of a double-buffered display memory. Scans the front bank row by
// row and serialises one colour bit plane at a time onto a HUB75-style panel.
// Brightness comes from binary-weighted show times. The block owns the bank
// select (flip) and swaps banks only at a frame boundary, on request from the
// writer through a swap_req/swap_ack handshake.
//
// Panel timing notes:
//  - Sequencing state advances every clk; every panel output is a register
//    loaded from that state, so it appears one clk after the state.
//  - In SHIFT, column c is addressed during counts 2c and 2c+1. The memory
//    returns it during count 2c+1, where it is captured into r/g/b. sclk
//    rises one clk later, so data is set up for a full clk before each rise.
module hub75_scan_reader #(
   parameter int rows         = 8,
   parameter int columns      = 32,
   parameter int width        = 24,
   parameter int planes       = 8,
   parameter int base_time    = 1,
   parameter int blank_cycles = 2
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       swap_req,
   output logic                       swap_ack,
   output logic                       flip,
   output logic [$clog2(rows)-1:0]    rrow,
   output logic [$clog2(columns)-1:0] rcol,
   input  logic [width-1:0]           rdata,
   output logic                       frame_start,
   output logic                       r,
   output logic                       g,
   output logic                       b,
   output logic                       sclk,
   output logic                       lat,
   output logic                       oe_n,
   output logic [$clog2(rows)-1:0]    addr
);

   localparam int RW        = $clog2(rows);
   localparam int CW        = $clog2(columns);
   localparam int PW        = (planes > 1) ? $clog2(planes) : 1;
   localparam int SHIFT_LEN = 2 * columns + 2;
   localparam int SHOW_MAX  = base_time << (planes - 1);
   localparam int MAX_A     = (SHIFT_LEN > SHOW_MAX) ? SHIFT_LEN : SHOW_MAX;
   localparam int CNT_MAX   = (MAX_A > blank_cycles) ? MAX_A : blank_cycles;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(SHIFT_LEN - 1);
   localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(SHIFT_LEN - 3);
   localparam logic [CNT_W-1:0] CLK_FIRST  = CNT_W'(2);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(blank_cycles - 1);
   localparam logic [RW-1:0]    ROW_LAST   = RW'(rows - 1);
   localparam logic [PW-1:0]    PLANE_LAST = PW'(planes - 1);
   localparam logic [2:0]       BIT_OFS    = 3'(8 - planes);

   localparam logic [1:0] ST_SHIFT = 2'd0;
   localparam logic [1:0] ST_BLANK = 2'd1;
   localparam logic [1:0] ST_LATCH = 2'd2;
   localparam logic [1:0] ST_SHOW  = 2'd3;

   logic [1:0]       state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [RW-1:0]    row_r;
   logic [PW-1:0]    plane_r;
   logic             flip_r;
   logic             swap_ack_r;
   logic             red_r;
   logic             grn_r;
   logic             blu_r;
   logic             sclk_r;
   logic             lat_r;
   logic             oe_n_r;
   logic [RW-1:0]    addr_r;
   logic             frame_start_r;

   logic [CNT_W-1:0] show_last_s;
   logic [2:0]       bit_idx_s;
   logic [7:0]       red_word_s;
   logic [7:0]       grn_word_s;
   logic [7:0]       blu_word_s;
   logic             frame_end_s;
   logic [CW-1:0]    rcol_s;

   // Per-plane show length, colour bit selection and frame-end detection.
   always_comb begin
      show_last_s = (CNT_W'(base_time) << plane_r) - CNT_W'(1);
      bit_idx_s   = BIT_OFS + 3'(plane_r);
      red_word_s  = rdata[23:16];
      grn_word_s  = rdata[15:8];
      blu_word_s  = rdata[7:0];
      frame_end_s = (plane_r == PLANE_LAST) && (row_r == ROW_LAST);
   end

   // Memory column address: two SHIFT counts per column, parked at 0 elsewhere.
   always_comb begin
      rcol_s = {CW{1'b0}};
      if (state_r == ST_SHIFT) begin
         rcol_s = cnt_r[CW:1];
      end else begin
         rcol_s = {CW{1'b0}};
      end
   end

   // Scan sequencer: SHIFT -> BLANK -> LATCH -> SHOW, then plane/row/bank advance.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_SHIFT;
         cnt_r      <= {CNT_W{1'b0}};
         row_r      <= {RW{1'b0}};
         plane_r    <= {PW{1'b0}};
         flip_r     <= 1'b0;
         swap_ack_r <= 1'b0;
      end else begin
         swap_ack_r <= 1'b0;
         case (state_r)
            ST_SHIFT: begin
               if (cnt_r == SHIFT_LAST) begin
                  state_r <= ST_BLANK;
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
               end
            end
            ST_BLANK: begin
               if (cnt_r == BLANK_LAST) begin
                  state_r <= ST_LATCH;
                  cnt_r   <= {CNT_W{1'b0}};
               end else begin
                  cnt_r   <= cnt_r + CNT_W'(1);
               end
            end
            ST_LATCH: begin
               state_r <= ST_SHOW;
               cnt_r   <= {CNT_W{1'b0}};
            end
            ST_SHOW: begin
               if (cnt_r == show_last_s) begin
                  state_r <= ST_SHIFT;
                  cnt_r   <= {CNT_W{1'b0}};
                  if (plane_r == PLANE_LAST) begin
                     plane_r <= {PW{1'b0}};
                     if (frame_end_s) begin
                        row_r <= {RW{1'b0}};
                        // Bank swap is only ever taken here, between frames.
                        if (swap_req) begin
                           flip_r     <= ~flip_r;
                           swap_ack_r <= 1'b1;
                        end
                     end else begin
                        row_r <= row_r + RW'(1);
                     end
                  end else begin
                     plane_r <= plane_r + PW'(1);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r <= ST_SHIFT;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Registered panel drive, derived from the sequencer state one clk earlier.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         red_r         <= 1'b0;
         grn_r         <= 1'b0;
         blu_r         <= 1'b0;
         sclk_r        <= 1'b0;
         lat_r         <= 1'b0;
         oe_n_r        <= 1'b1;
         addr_r        <= {RW{1'b0}};
         frame_start_r <= 1'b0;
      end else begin
         sclk_r <= (state_r == ST_SHIFT) && !cnt_r[0] && (cnt_r >= CLK_FIRST);
         if ((state_r == ST_SHIFT) && cnt_r[0] && (cnt_r <= DATA_LAST)) begin
            red_r <= red_word_s[bit_idx_s];
            grn_r <= grn_word_s[bit_idx_s];
            blu_r <= blu_word_s[bit_idx_s];
         end
         lat_r  <= (state_r == ST_LATCH);
         oe_n_r <= (state_r != ST_SHOW);
         if (state_r == ST_LATCH) begin
            addr_r <= row_r;
         end
         frame_start_r <= (state_r == ST_SHIFT) && (cnt_r == {CNT_W{1'b0}}) &&
                          (row_r == {RW{1'b0}}) && (plane_r == {PW{1'b0}});
      end
   end

   assign swap_ack    = swap_ack_r;
   assign flip        = flip_r;
   assign rrow        = row_r;
   assign rcol        = rcol_s;
   assign frame_start = frame_start_r;
   assign r           = red_r;
   assign g           = grn_r;
   assign b           = blu_r;
   assign sclk        = sclk_r;
   assign lat         = lat_r;
   assign oe_n        = oe_n_r;
   assign addr        = addr_r;

endmodule
